// File: rtl/pc_stack_hs.sv
// Handshake-driven program counter with a return-address stack for CALL/RET.
// The fetch address is offered on pc_valid/pc_ready; one sequencing command is then taken on cmd_valid/cmd_ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RST    | held in or just out of reset; nothing offered, no command
// S_PRES   | pc_out offered to fetch, held stable until pc_ready
// S_WAIT   | waiting for the sequencing command for the fetched address
module pc_stack_hs #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int DEPTH    = 4,
    parameter int RST_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [WIDTH-1:0]             pc_out,
    output logic                         pc_valid,
    input  logic                         pc_ready,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [WIDTH-1:0]             cmd_arg,
    output logic [$clog2(DEPTH+1)-1:0]   stk_count,
    output logic                         err_ovf,
    output logic                         err_unf,
    input  logic                         err_clr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0]    FULL   = CW'(DEPTH);
    localparam logic [CW-1:0]    ONE_C  = CW'(1);
    localparam logic [WIDTH-1:0] STEP1  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] STEP2  = WIDTH'(2 * STEP);
    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RST_ADDR);

    localparam logic [1:0] S_RST  = 2'd0;
    localparam logic [1:0] S_PRES = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_BRR  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_SKIP = 3'b110;

    logic [1:0]       state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] stack [0:(1<<IW)-1];

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] pc_nxt;
    logic [CW-1:0]    top_cnt;
    logic             accept;
    logic             do_push;
    logic             do_pop;
    logic             ovf_hit;
    logic             unf_hit;

    assign pc_out    = pc;
    assign pc_valid  = (state == S_PRES);
    assign cmd_ready = (state == S_WAIT);
    assign accept    = cmd_ready && cmd_valid;
    assign seq_pc    = pc + STEP1;
    assign top_cnt   = stk_count - ONE_C;

    always_comb begin
        pc_nxt  = pc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        ovf_hit = 1'b0;
        unf_hit = 1'b0;
        case (cmd_op)
            OP_SEQ:  pc_nxt = seq_pc;
            OP_JMP:  pc_nxt = cmd_arg;
            OP_BRR:  pc_nxt = pc + cmd_arg;
            OP_SKIP: pc_nxt = pc + STEP2;
            OP_CALL: begin
                pc_nxt = cmd_arg;
                if (stk_count == FULL) ovf_hit = 1'b1;
                else                   do_push = 1'b1;
            end
            OP_RET: begin
                // An empty-stack return falls through to the next address.
                if (stk_count == '0) begin
                    pc_nxt  = seq_pc;
                    unf_hit = 1'b1;
                end else begin
                    pc_nxt = stack[top_cnt[IW-1:0]];
                    do_pop = 1'b1;
                end
            end
            default: pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RST;
            pc        <= RST_PC;
            stk_count <= '0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            case (state)
                S_RST:   state <= S_PRES;
                S_PRES:  if (pc_ready) state <= S_WAIT;
                S_WAIT:  if (cmd_valid) state <= S_PRES;
                default: state <= S_RST;
            endcase
            if (accept) begin
                pc <= pc_nxt;
                if (do_push) stk_count <= stk_count + ONE_C;
                if (do_pop)  stk_count <= stk_count - ONE_C;
            end
            // A new error wins over a coincident clear.
            err_ovf <= (err_ovf && !err_clr) || (accept && ovf_hit);
            err_unf <= (err_unf && !err_clr) || (accept && unf_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept && do_push)
            stack[stk_count[IW-1:0]] <= seq_pc;
    end

endmodule

// File: tb/tb_pc_stack_hs.sv
// Directed bench for pc_stack_hs: commands push expected presentations into a queue,
// a negedge monitor pops one entry on every new pc_valid presentation and compares.
module tb_pc_stack_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc_out;
    logic       pc_valid;
    logic       pc_ready;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_arg;
    logic [2:0] stk_count;
    logic       err_ovf;
    logic       err_unf;
    logic       err_clr;

    typedef struct {
        logic [7:0] pc;
        logic [2:0] cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic prev_v = 1'b0;

    localparam logic [2:0] SEQ  = 3'b000;
    localparam logic [2:0] HOLD = 3'b001;
    localparam logic [2:0] JMP  = 3'b010;
    localparam logic [2:0] BRR  = 3'b011;
    localparam logic [2:0] CALL = 3'b100;
    localparam logic [2:0] RET  = 3'b101;
    localparam logic [2:0] SKIP = 3'b110;
    localparam logic [2:0] RSV  = 3'b111;

    pc_stack_hs #(.WIDTH(8), .STEP(1), .DEPTH(4), .RST_ADDR(0)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .stk_count(stk_count), .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_pres(input logic [7:0] p, input logic [2:0] c, input logic o, input logic u);
        exp_t e;
        e.pc = p; e.cnt = c; e.ovf = o; e.unf = u;
        exp_q.push_back(e);
    endtask

    // Monitor: one scoreboard entry per new presentation.
    always @(negedge clk) begin
        if (pc_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                check("unexpected_presentation", 32'(pc_out), 32'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pres_pc", 32'(pc_out), 32'(e.pc));
                check("pres_stk_count", 32'(stk_count), 32'(e.cnt));
                check("pres_flags", 32'({err_ovf, err_unf}), 32'({e.ovf, e.unf}));
            end
        end
        prev_v = pc_valid;
    end

    task automatic do_cmd(input logic [2:0] op, input logic [7:0] arg,
                          input logic [7:0] epc, input logic [2:0] ecnt,
                          input logic eo, input logic eu, input logic clr = 1'b0);
        int n = 0;
        while (!pc_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!pc_valid) check("pc_valid_timeout", 32'(pc_valid), 32'd1);
        pc_ready = 1'b1;
        @(posedge clk); #1;
        pc_ready = 1'b0;
        check("wait_cmd_handshake", 32'({pc_valid, cmd_ready}), 32'b01);
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_valid = 1'b1;
        err_clr   = clr;
        expect_pres(epc, ecnt, eo, eu);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_ready = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000;
        cmd_arg = 8'h00; err_clr = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_state", 32'({pc_valid, cmd_ready, pc_out, stk_count, err_ovf, err_unf}), 32'h0);
        end
        @(posedge clk); #1;
        expect_pres(8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        check("valid_low_at_release", 32'(pc_valid), 32'd0);
        @(posedge clk); #1;
        check("valid_one_cycle_after_release", 32'(pc_valid), 32'd1);

        // SEQ wrap
        do_cmd(JMP, 8'hFE, 8'hFE, 3'd0, 1'b0, 1'b0);
        do_cmd(SEQ, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0);
        do_cmd(SEQ, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // Branches, skip, hold
        do_cmd(JMP,  8'h10, 8'h10, 3'd0, 1'b0, 1'b0);
        do_cmd(BRR,  8'hF0, 8'h00, 3'd0, 1'b0, 1'b0);
        do_cmd(BRR,  8'h05, 8'h05, 3'd0, 1'b0, 1'b0);
        do_cmd(SKIP, 8'h00, 8'h07, 3'd0, 1'b0, 1'b0);
        do_cmd(HOLD, 8'h33, 8'h07, 3'd0, 1'b0, 1'b0);
        do_cmd(RSV,  8'h44, 8'h07, 3'd0, 1'b0, 1'b0);

        // Nesting
        do_cmd(JMP,  8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        do_cmd(CALL, 8'h40, 8'h40, 3'd1, 1'b0, 1'b0);
        do_cmd(CALL, 8'h80, 8'h80, 3'd2, 1'b0, 1'b0);
        do_cmd(RET,  8'h00, 8'h41, 3'd1, 1'b0, 1'b0);
        do_cmd(RET,  8'h00, 8'h01, 3'd0, 1'b0, 1'b0);

        // Overflow then underflow; bottom return address is 0x05
        do_cmd(JMP,  8'h04, 8'h04, 3'd0, 1'b0, 1'b0);
        do_cmd(CALL, 8'h10, 8'h10, 3'd1, 1'b0, 1'b0);
        do_cmd(CALL, 8'h20, 8'h20, 3'd2, 1'b0, 1'b0);
        do_cmd(CALL, 8'h30, 8'h30, 3'd3, 1'b0, 1'b0);
        do_cmd(CALL, 8'h40, 8'h40, 3'd4, 1'b0, 1'b0);
        do_cmd(CALL, 8'h50, 8'h50, 3'd4, 1'b1, 1'b0);
        do_cmd(RET,  8'h00, 8'h31, 3'd3, 1'b1, 1'b0);
        do_cmd(RET,  8'h00, 8'h21, 3'd2, 1'b1, 1'b0);
        do_cmd(RET,  8'h00, 8'h11, 3'd1, 1'b1, 1'b0);
        do_cmd(RET,  8'h00, 8'h05, 3'd0, 1'b1, 1'b0);
        do_cmd(RET,  8'h00, 8'h06, 3'd0, 1'b1, 1'b1);

        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("err_clr_pulse", 32'({err_ovf, err_unf}), 32'b00);
        do_cmd(RET, 8'h00, 8'h07, 3'd0, 1'b0, 1'b1, 1'b1);

        // Backpressure: command must be ignored while presenting
        cmd_valid = 1'b1; cmd_op = JMP; cmd_arg = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("backpressure_hold", 32'({pc_out, pc_valid, cmd_ready, stk_count}), 32'({8'h07, 1'b1, 1'b0, 3'd0}));
        end
        cmd_valid = 1'b0;

        do_cmd(CALL, 8'h20, 8'h20, 3'd1, 1'b0, 1'b1);
        do_cmd(CALL, 8'h30, 8'h30, 3'd2, 1'b0, 1'b1);
        do_cmd(CALL, 8'h40, 8'h40, 3'd3, 1'b0, 1'b1);

        // Reset in WAIT_CMD with a command pending
        pc_ready = 1'b1;
        @(posedge clk); #1;
        pc_ready = 1'b0;
        check("pre_reset_wait_cmd", 32'({cmd_ready, stk_count}), 32'({1'b1, 3'd3}));
        cmd_valid = 1'b1; cmd_op = RET; rst = 1'b1;
        expect_pres(8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; cmd_valid = 1'b0;
        check("mid_reset_state", 32'({pc_valid, cmd_ready, pc_out, stk_count, err_ovf, err_unf}), 32'h0);
        @(posedge clk); #1;
        check("mid_reset_valid_after_release", 32'(pc_valid), 32'd1);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pc_stack_hs.md
Name: pc_stack_hs

Overview:
- Synchronous, parametrised program counter: next generation of the handshake-driven PC.
- Presents the current fetch address to the fetch stage over a valid/ready channel, then accepts one sequencing command per fetched address.
- Commands: sequential, hold, skip, absolute jump, signed relative branch, call, return.
- Call/return use an internal return-address stack (LIFO) with sticky overflow/underflow flags.

Parameters:
WIDTH, 8, address width in bits (>=2)
STEP, 1, sequential increment in address units
DEPTH, 4, return-stack entries (>=1)
RST_ADDR, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
pc_out  out  WIDTH  current PC
pc_valid  out  1  pc_out ready to be fetched
pc_ready  in  1  fetch stage consumes pc_out
cmd_valid  in  1  sequencing command present
cmd_ready  out  1  block accepts a command
cmd_op  in  3  command opcode
cmd_arg  in  WIDTH  target address or signed offset
stk_count  out  $clog2(DEPTH+1)  return-stack occupancy, 0..DEPTH
err_ovf  out  1  sticky: CALL issued with stack full
err_unf  out  1  sticky: RET issued with stack empty
err_clr  in  1  clears err_ovf/err_unf

Behaviour:
- Interface: one clock, synchronous active-high reset; all outputs registered or decoded from the state register.
- Reset:
  - rst high at a clock edge: state=RST, pc_out=RST_ADDR, pc_valid=0, cmd_ready=0, stk_count=0, err_ovf=err_unf=0.
  - Applies mid-operation: stack contents are discarded and any pending command is dropped.
- FSM states:
  - RST: pc_valid=0, cmd_ready=0. Next edge with rst low goes to PRESENT, so pc_valid rises one cycle after rst deasserts.
  - PRESENT: pc_valid=1, cmd_ready=0. pc_ready=1 goes to WAIT_CMD; otherwise stay, and pc_out is held stable.
  - WAIT_CMD: pc_valid=0, cmd_ready=1. cmd_valid=1 updates PC/stack and goes to PRESENT; otherwise stay.
- Handshake rules:
  - pc_ready is ignored unless pc_valid=1.
  - cmd_valid is ignored unless cmd_ready=1; there is no command buffering.
  - cmd_op and cmd_arg are sampled only on the accept edge.
  - Latency: command accept edge to new pc_valid=1 is 1 cycle. Minimum loop is 2 cycles per address.
- Opcodes (P = current PC; all arithmetic modulo 2^WIDTH, wraps silently):
  - 000 SEQ: P+STEP
  - 001 HOLD: P (same address re-presented)
  - 010 JMP: cmd_arg
  - 011 BRR: P + cmd_arg, with cmd_arg as two's-complement signed
  - 100 CALL: push P+STEP; PC=cmd_arg
  - 101 RET: PC=pop
  - 110 SKIP: P+2*STEP
  - 111 reserved: behaves as HOLD; no flag.
- Stack boundaries:
  - CALL with stk_count=DEPTH: jump still taken, push discarded, stk_count unchanged, err_ovf set.
  - RET with stk_count=0: PC=P+STEP, err_unf set.
  - Stack entries are unaffected by non-CALL/RET ops.
- Error flags:
  - Sticky until err_clr=1 or reset.
  - If err_clr and a new error occur in the same cycle, the flag ends set.
  - err_clr is legal in any state.
- stk_count updates on the same edge as the PC.

Test Plan:
- Reset: rst=1 for 3 cycles, RST_ADDR=0x00 -> pc_valid=0, pc_out=0x00, stk_count=0 throughout; the cycle after release pc_valid=1, pc_out=0x00.
- SEQ wrap: JMP 0xFE, then SEQ twice, pc_ready tied 1 -> pc_out sequence 0xFE, 0xFF, 0x00; pc_valid alternates 1/0 each cycle.
- BRR: PC=0x10, BRR arg=0xF0 -> 0x00; BRR arg=0x05 -> 0x05; SKIP from 0x05 (STEP=1) -> 0x07; HOLD/op 111 -> 0x07 re-presented.
- Nesting, DEPTH=4, starting at PC 0x00:
  - CALL 0x40, then CALL 0x80 -> stk_count=2, pc_out=0x80.
  - RET -> 0x41; RET -> 0x01, stk_count=0, no flags.
- Overflow/underflow: 5 CALLs (args 0x10..0x50) -> stk_count=4, err_ovf=1, pc_out=0x50. Then 5 RETs -> four pops, fifth gives 0x05+STEP, err_unf=1. err_clr pulse -> both flags 0; err_clr coincident with a new RET-on-empty -> err_unf stays 1.
- Backpressure and reset mid-operation:
  - pc_ready=0 for 5 cycles with cmd_valid=1 -> pc_out stable, cmd_ready=0, no PC change.
  - With stk_count=3, assert rst for 1 cycle in WAIT_CMD with cmd_valid=1 -> command dropped, stk_count=0, pc_out=RST_ADDR, pc_valid=1 one cycle after release.
